dm_sized: RTL and testbench

DM_SIZED -- requirements
Module: dm_sized

---
 rtl/dm_sized_if.sv | 25 ++
 rtl/dm_sized.sv | 119 +++++++++++
 tb/tb_dm_sized.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dm_sized_if.sv
// Bus bundle for the dm_sized byte-addressable, big-endian data memory.
// The master drives requests and the slave (memory) returns read data and error status.
interface dm_sized_if;
   logic [31:0] Mem_addr;
   logic [31:0] Mem_w_data;
   logic        Mem_w;
   logic        Mem_r;
   logic [1:0]  Mem_size;
   logic        Mem_unsigned;
   logic        Err_clr;
   logic [31:0] Mem_r_data;
   logic        Mem_r_valid;
   logic        Mem_err;
   logic [31:0] Err_addr;

   modport master (
      output Mem_addr, Mem_w_data, Mem_w, Mem_r, Mem_size, Mem_unsigned, Err_clr,
      input  Mem_r_data, Mem_r_valid, Mem_err, Err_addr
   );

   modport slave (
      input  Mem_addr, Mem_w_data, Mem_w, Mem_r, Mem_size, Mem_unsigned, Err_clr,
      output Mem_r_data, Mem_r_valid, Mem_err, Err_addr
   );
endinterface

// File: rtl/dm_sized.sv
// Sized (byte/half/word) big-endian data memory with registered reads and sticky misalignment capture.
// Optional macro DM_MISALIGN_TRAP_EN: misaligned writes are dropped and misaligned reads return zero.
module dm_sized #(
   parameter int MEM_BYTES = 128,
   parameter int DATA_W    = 32
) (
   input logic        clk,
   input logic        rst_n,
   dm_sized_if.slave  bus
);

   localparam int AW = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   logic [7:0]        mem_q [MEM_BYTES];
   logic [7:0]        mem_d [MEM_BYTES];
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic [31:0]       err_addr_q, err_addr_d;

   size_e             size;
   logic [AW-1:0]     idx0, idx1, idx2, idx3;
   logic              misalign;
   logic              suppress;
   logic              sign;
   logic              err_set;
   logic [DATA_W-1:0] load_val;

   assign size = size_e'(bus.Mem_size);

   // Byte lanes wrap naturally through AW-bit arithmetic; idx0 always holds the MSB.
   assign idx0 = bus.Mem_addr[AW-1:0];
   assign idx1 = idx0 + AW'(1);
   assign idx2 = idx0 + AW'(2);
   assign idx3 = idx0 + AW'(3);

   assign misalign = ((size == SZ_HALF) && bus.Mem_addr[0]) ||
                     ((size == SZ_WORD || size == SZ_RSVD) && (bus.Mem_addr[1:0] != 2'b00));

`ifdef DM_MISALIGN_TRAP_EN
   assign suppress = misalign;
`else
   assign suppress = 1'b0;
`endif

   assign sign = ~bus.Mem_unsigned & mem_q[idx0][7];

   // Load path reads mem_q, so a same-edge write is never visible to the read.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      load_val = '0;
      case (size)
         SZ_BYTE: load_val = {{24{sign}}, mem_q[idx0]};
         SZ_HALF: load_val = {{16{sign}}, mem_q[idx0], mem_q[idx1]};
         default: load_val = {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};
      endcase
      if (suppress) load_val = '0;
   end

   always_comb begin
      mem_d = mem_q;
      if (bus.Mem_w && !suppress) begin
         case (size)
            SZ_BYTE: mem_d[idx0] = bus.Mem_w_data[7:0];
            SZ_HALF: begin
               mem_d[idx0] = bus.Mem_w_data[15:8];
               mem_d[idx1] = bus.Mem_w_data[7:0];
            end
            default: begin
               mem_d[idx0] = bus.Mem_w_data[31:24];
               mem_d[idx1] = bus.Mem_w_data[23:16];
               mem_d[idx2] = bus.Mem_w_data[15:8];
               mem_d[idx3] = bus.Mem_w_data[7:0];
            end
         endcase
      end
   end

   // A new fault while clearing re-arms the capture: set wins over clear.
   assign err_set = (bus.Mem_r || bus.Mem_w) && misalign && (!err_q || bus.Err_clr);

   always_comb begin
      rdata_d    = bus.Mem_r ? load_val : rdata_q;
      valid_d    = bus.Mem_r;
      err_d      = err_set ? 1'b1 : (bus.Err_clr ? 1'b0 : err_q);
      err_addr_d = err_set ? bus.Mem_addr : err_addr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array sits in the async reset on purpose, since every byte must read zero after reset.
         for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
         rdata_q    <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         mem_q      <= mem_d;
         rdata_q    <= rdata_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign bus.Mem_r_data  = rdata_q;
   assign bus.Mem_r_valid = valid_q;
   assign bus.Mem_err     = err_q;
   assign bus.Err_addr    = err_addr_q;

endmodule

// File: tb/tb_dm_sized.sv
// Directed scoreboard bench for dm_sized: reads push expected data, a negedge monitor pops and compares.
// Expectations for misaligned accesses follow DM_MISALIGN_TRAP_EN when it is defined.
module tb_dm_sized;

   localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

   typedef struct {
      logic [31:0] data;
      string       tag;
   } exp_t;

   logic clk;
   logic rst_n;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   exp_t exp_q[$];

   dm_sized_if bus ();

   dm_sized #(.MEM_BYTES(128), .DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every valid cycle must match the oldest outstanding read.
   always @(negedge clk) begin
      if (rst_n && bus.Mem_r_valid) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_valid: got Mem_r_valid=1 data=%h expected no valid", bus.Mem_r_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, bus.Mem_r_data, e.data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      bus.Mem_r = 1'b0;
      bus.Mem_w = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
      bus.Mem_addr = addr; bus.Mem_size = sz; bus.Mem_w_data = data; bus.Mem_w = 1'b1;
      step();
   endtask

   task automatic rd(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] exp, input string tag);
      exp_t e;
      bus.Mem_addr = addr; bus.Mem_size = sz; bus.Mem_unsigned = uns; bus.Mem_r = 1'b1;
      e.data = exp; e.tag = tag;
      exp_q.push_back(e);
      step();
   endtask

   task automatic rw(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data,
                     input logic [31:0] exp, input string tag);
      bus.Mem_w_data = data; bus.Mem_w = 1'b1;
      rd(addr, sz, 1'b0, exp, tag);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

`ifdef DM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   initial begin
      rst_n = 1'b0;
      bus.Mem_addr = '0; bus.Mem_w_data = '0; bus.Mem_w = 1'b0; bus.Mem_r = 1'b0;
      bus.Mem_size = W; bus.Mem_unsigned = 1'b0; bus.Err_clr = 1'b0;

      #12;
      check("rst_r_data", bus.Mem_r_data, 32'h0);
      check("rst_r_valid", {31'b0, bus.Mem_r_valid}, 32'h0);
      check("rst_err", {31'b0, bus.Mem_err}, 32'h0);
      check("rst_err_addr", bus.Err_addr, 32'h0);
      rst_n = 1'b1;

      // Basic word/byte/half, big-endian, extension
      wr(32'h10, W, 32'h11223344);
      rd(32'h10, W, 1'b0, 32'h11223344, "w_rd10");
      rd(32'h11, B, 1'b1, 32'h00000022, "b_rd11_u");
      rd(32'h12, H, 1'b0, 32'h00003344, "h_rd12_s");
      wr(32'h20, B, 32'h12345680);
      rd(32'h20, B, 1'b0, 32'hFFFFFF80, "b_rd20_s");
      rd(32'h20, B, 1'b1, 32'h00000080, "b_rd20_u");
      wr(32'h20, H, 32'hABCD7FFF);
      rd(32'h20, H, 1'b0, 32'h00007FFF, "h_rd20_s");
      wr(32'h22, H, 32'h00008001);
      rd(32'h22, H, 1'b0, 32'hFFFF8001, "h_rd22_s");
      rd(32'h22, H, 1'b1, 32'h00008001, "h_rd22_u");
      rd(32'h20, W, 1'b0, 32'h7FFF8001, "w_rd20");

      // Read-before-write on the same edge
      wr(32'h7C, W, 32'hAABBCCDD);
      rw(32'h7C, W, 32'h01020304, 32'hAABBCCDD, "rw_old7c");
      rd(32'h7C, W, 1'b0, 32'h01020304, "w_rd7c_new");

      // Reserved size behaves as word
      wr(32'h30, R, 32'hCAFEF00D);
      rd(32'h30, W, 1'b0, 32'hCAFEF00D, "w_rd30");
      rd(32'h30, R, 1'b0, 32'hCAFEF00D, "r_rd30");
      rd(32'h31, B, 1'b0, 32'hFFFFFFFE, "b_rd31_s");
      idle(2);
      check("hold_r_data", bus.Mem_r_data, 32'hFFFFFFFE);
      check("idle_valid", {31'b0, bus.Mem_r_valid}, 32'h0);
      check("aligned_no_err", {31'b0, bus.Mem_err}, 32'h0);

      // Misaligned word at the top of memory wraps to bytes 0..2
      wr(32'h7F, W, 32'hDEADBEEF);
      check("mis_err_set", {31'b0, bus.Mem_err}, 32'h1);
      check("mis_err_addr", bus.Err_addr, 32'h7F);
      rd(32'h7F, B, 1'b1, TRAP ? 32'h04 : 32'hDE, "wrap_b7f");
      rd(32'h00, B, 1'b1, TRAP ? 32'h00 : 32'hAD, "wrap_b00");
      rd(32'h01, B, 1'b1, TRAP ? 32'h00 : 32'hBE, "wrap_b01");
      rd(32'h02, B, 1'b1, TRAP ? 32'h00 : 32'hEF, "wrap_b02");
      rd(32'h7C, W, 1'b1, TRAP ? 32'h01020304 : 32'h010203DE, "wrap_w7c");
      rd(32'h05, H, 1'b1, 32'h0, "mis_h05");
      check("err_addr_sticky", bus.Err_addr, 32'h7F);
      bus.Err_clr = 1'b1; step(); bus.Err_clr = 1'b0;
      check("err_clr", {31'b0, bus.Mem_err}, 32'h0);

      // Fresh capture, then clear and new fault on the same edge
      rd(32'h42, W, 1'b1, 32'h0, "mis_w42");
      check("err_set2", {31'b0, bus.Mem_err}, 32'h1);
      check("err_addr2", bus.Err_addr, 32'h42);
      bus.Err_clr = 1'b1;
      rd(32'h81, H, 1'b1, TRAP ? 32'h0 : 32'h0000BEEF, "mis_h81");
      bus.Err_clr = 1'b0;
      check("clr_set_wins", {31'b0, bus.Mem_err}, 32'h1);
      check("clr_set_addr", bus.Err_addr, 32'h81);
      bus.Err_clr = 1'b1; step(); bus.Err_clr = 1'b0;

      // Misaligned half write
      wr(32'h03, H, 32'h00001234);
      check("h03_err", {31'b0, bus.Mem_err}, 32'h1);
      check("h03_err_addr", bus.Err_addr, 32'h03);
      rd(32'h03, H, 1'b1, TRAP ? 32'h0 : 32'h00001234, "mis_h03");
      rd(32'h03, B, 1'b1, TRAP ? 32'h0 : 32'h00000012, "b_rd03");
      rd(32'h04, B, 1'b1, TRAP ? 32'h0 : 32'h00000034, "b_rd04");
      idle(1);

      // Asynchronous reset mid-cycle, with a write pending across the edge
      #2 rst_n = 1'b0;
      #1;
      check("arst_r_data", bus.Mem_r_data, 32'h0);
      check("arst_valid", {31'b0, bus.Mem_r_valid}, 32'h0);
      check("arst_err", {31'b0, bus.Mem_err}, 32'h0);
      check("arst_err_addr", bus.Err_addr, 32'h0);
      bus.Mem_addr = 32'h10; bus.Mem_size = W; bus.Mem_w_data = 32'h55555555; bus.Mem_w = 1'b1;
      step();
      #2 rst_n = 1'b1;
      rd(32'h10, W, 1'b0, 32'h0, "post_rst_w10");
      rd(32'h7C, W, 1'b0, 32'h0, "post_rst_w7c");
      rd(32'h20, W, 1'b0, 32'h0, "post_rst_w20");

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      check("rd_queue_drained", exp_q.size(), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
